// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - host-side holding-register handshake of uart_receiver
interface uart_receiver_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ack;
  logic                 rts;
  logic                 framing_error;
  logic                 overrun;
  logic                 parity_error;

  modport master (
    output data, valid, rts, framing_error, overrun, parity_error,
    input  ack
  );

  modport slave (
    input  data, valid, rts, framing_error, overrun, parity_error,
    output ack
  );
endinterface

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with one-byte holding register and rts handshake
// Optional even-parity bit between data and stop enabled by defining UART_RX_PARITY_EN.
module uart_receiver #(
  parameter int TICK_DIV  = 326,
  parameter int DATA_BITS = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            rx,
  uart_receiver_if.master host
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [3:0]           sample_q, sample_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 rts_q, rts_d;
  logic                 framing_err_q, framing_err_d;
  logic                 overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bad_q, parity_bad_d;
  logic                 parity_err_q, parity_err_d;
`endif

  logic rxs;
  logic tick;
  logic bit_tick;
  logic frame_ok;

  assign rxs      = sync_q[1];
  assign tick     = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign bit_tick = tick && (sample_q == 4'hF);

  always_comb begin
    state_d       = state_q;
    sync_d        = {sync_q[0], rx};
    tick_cnt_d    = tick ? '0 : tick_cnt_q + 1'b1;
    sample_d      = tick ? sample_q + 1'b1 : sample_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    framing_err_d = 1'b0;
    frame_ok      = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_d  = parity_bad_q;
    parity_err_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Restart the tick phase at the falling edge so ticks land mid-bit.
        if (!rxs) begin
          state_d    = START;
          tick_cnt_d = '0;
          sample_d   = '0;
        end
      end
      START: begin
        if (tick && sample_q == 4'd7) begin
          if (rxs) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            sample_d  = '0;
            bit_cnt_d = '0;
          end
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_d   = {rxs, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          parity_bad_d = rxs ^ (^shift_q);
          state_d      = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          if (rxs) begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            frame_ok     = !parity_bad_q;
            parity_err_d = parity_bad_q;
`else
            frame_ok = 1'b1;
`endif
          end else begin
            framing_err_d = 1'b1;
            state_d       = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    // An ack in the completion cycle frees the slot for the new byte.
    if (frame_ok) begin
      if (!valid_q || host.ack) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && host.ack) begin
      valid_d = 1'b0;
    end
    rts_d = ~valid_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      sync_q        <= 2'b11;
      tick_cnt_q    <= '0;
      sample_q      <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      rts_q         <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q  <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      tick_cnt_q    <= tick_cnt_d;
      sample_q      <= sample_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      rts_q         <= rts_d;
      framing_err_q <= framing_err_d;
      overrun_q     <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_bad_q  <= parity_bad_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign host.data          = data_q;
  assign host.valid         = valid_q;
  assign host.rts           = rts_q;
  assign host.framing_error = framing_err_q;
  assign host.overrun       = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign host.parity_error  = parity_err_q;
`else
  assign host.parity_error  = 1'b0;
`endif
endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - randomized self-checking bench for uart_receiver
`timescale 1ns/1ps
module tb_uart_receiver;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = 16 * TICK_DIV;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Start-bit midpoint plus the remaining bits up to the stop midpoint, +4 for sync/register slack.
  localparam int LAT_MIN = BIT_CLKS / 2 + (FRAME_BITS - 1) * BIT_CLKS;
  localparam int LAT_MAX = LAT_MIN + 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic rx    = 1'b1;

  uart_receiver_if #(.DATA_BITS(8)) host_if ();

  uart_receiver #(.TICK_DIV(TICK_DIV), .DATA_BITS(8)) dut (
    .clock (clock),
    .reset (reset),
    .rx    (rx),
    .host  (host_if)
  );

  always #5 clock = ~clock;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   fe_cnt = 0;
  int   ovr_cnt = 0;
  int   pe_cnt = 0;
  int   rise_cyc = -1;
  int   start_cyc = 0;
  int   lat = LAT_MIN + 3;
  logic valid_prev = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (host_if.framing_error === 1'b1) fe_cnt++;
    if (host_if.overrun === 1'b1) ovr_cnt++;
    if (host_if.parity_error === 1'b1) pe_cnt++;
    if (host_if.valid === 1'b1 && valid_prev !== 1'b1) rise_cyc = cyc;
    valid_prev = host_if.valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    start_cyc = cyc;
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      repeat (BIT_CLKS) @(negedge clock);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_val);
`ifdef UART_RX_PARITY_EN
    send_bits({stop_val, ^b, b, 1'b0}, 11);
`else
    send_bits({1'b0, stop_val, b, 1'b0}, 10);
`endif
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (host_if.valid !== 1'b1 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_valid"}, 32'(host_if.valid), 32'd1);
  endtask

  task automatic do_ack();
    host_if.ack = 1'b1;
    @(negedge clock);
    host_if.ack = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, ovr0, pe0;
    logic [7:0] b;
    logic [7:0] e;
    host_if.ack = 1'b0;

    // Reset held while the line toggles.
    repeat (3) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = i[0];
      @(negedge clock);
    end
    rx = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_data", 32'(host_if.data), 32'h0);
    check("rst_valid", 32'(host_if.valid), 32'd0);
    check("rst_rts", 32'(host_if.rts), 32'd0);
    check("rst_pulses", 32'({host_if.framing_error, host_if.overrun, host_if.parity_error}), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("rts_after_release", 32'(host_if.rts), 32'd1);

    // 0xA5 with latency window, then ack.
    repeat (5) @(negedge clock);
    rise_cyc = -1;
    send_frame(8'hA5, 1'b1);
    wait_valid("a5");
    if (rise_cyc >= 0) lat = rise_cyc - start_cyc;
    check("a5_latency_in_window", 32'(lat >= LAT_MIN && lat <= LAT_MAX), 32'd1);
    if (lat < LAT_MIN || lat > LAT_MAX) lat = LAT_MIN + 3;
    check("a5_data", 32'(host_if.data), 32'hA5);
    check("a5_rts", 32'(host_if.rts), 32'd0);
    do_ack();
    check("a5_ack_valid", 32'(host_if.valid), 32'd0);
    check("a5_ack_rts", 32'(host_if.rts), 32'd1);

    // Start-bit glitch is ignored.
    fe0 = fe_cnt;
    rise_cyc = -1;
    rx = 1'b0;
    repeat (20) @(negedge clock);
    rx = 1'b1;
    repeat (200) @(negedge clock);
    check("glitch_no_valid", 32'(rise_cyc == -1), 32'd1);
    check("glitch_no_fe", 32'(fe_cnt - fe0), 32'd0);
    send_frame(8'h3C, 1'b1);
    wait_valid("3c");
    check("3c_data", 32'(host_if.data), 32'h3C);
    do_ack();

    // Framing error with the line held low afterwards.
    fe0 = fe_cnt;
    send_frame(8'h81, 1'b0);
    repeat (200) @(negedge clock);
    rx = 1'b1;
    repeat (50) @(negedge clock);
    check("fe_pulses", 32'(fe_cnt - fe0), 32'd1);
    check("fe_valid", 32'(host_if.valid), 32'd0);
    send_frame(8'h55, 1'b1);
    wait_valid("55");
    check("55_data", 32'(host_if.data), 32'h55);
    do_ack();

    // Overrun: second byte dropped while the first is unacknowledged.
    send_frame(8'h11, 1'b1);
    wait_valid("11");
    ovr0 = ovr_cnt;
    repeat (20) @(negedge clock);
    send_frame(8'h22, 1'b1);
    repeat (20) @(negedge clock);
    check("ovr_pulses", 32'(ovr_cnt - ovr0), 32'd1);
    check("ovr_data_kept", 32'(host_if.data), 32'h11);
    check("ovr_valid", 32'(host_if.valid), 32'd1);

    // Ack landing in the completion cycle accepts the new byte.
    ovr0 = ovr_cnt;
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (lat - 1) @(negedge clock);
        host_if.ack = 1'b1;
        @(negedge clock);
        host_if.ack = 1'b0;
      end
    join
    repeat (5) @(negedge clock);
    check("ackdone_data", 32'(host_if.data), 32'h22);
    check("ackdone_valid", 32'(host_if.valid), 32'd1);
    check("ackdone_no_ovr", 32'(ovr_cnt - ovr0), 32'd0);
    do_ack();

    // Reset mid-frame delivers nothing.
    fe0 = fe_cnt;
    rx = 1'b0;
    repeat (300) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    rx = 1'b1;
    reset = 1'b1;
    repeat (700) @(negedge clock);
    check("midrst_valid", 32'(host_if.valid), 32'd0);
    check("midrst_fe", 32'(fe_cnt - fe0), 32'd0);
    check("midrst_rts", 32'(host_if.rts), 32'd1);

    // Randomized traffic against a byte-queue model.
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      repeat ($urandom_range(1, 40)) @(negedge clock);
      send_frame(b, 1'b1);
      wait_valid("rand");
      e = exp_q.pop_front();
      check("rand_data", 32'(host_if.data), 32'(e));
      check("rand_rts", 32'(host_if.rts), 32'd0);
      repeat ($urandom_range(0, 30)) @(negedge clock);
      do_ack();
    end

`ifdef UART_RX_PARITY_EN
    pe0 = pe_cnt;
    send_bits({1'b1, 1'b1, 8'h07, 1'b0}, 11);
    wait_valid("par_good");
    check("par_good_data", 32'(host_if.data), 32'h07);
    check("par_good_no_pe", 32'(pe_cnt - pe0), 32'd0);
    do_ack();
    pe0 = pe_cnt;
    ovr0 = ovr_cnt;
    send_bits({1'b1, 1'b0, 8'h07, 1'b0}, 11);
    repeat (20) @(negedge clock);
    check("par_bad_pe", 32'(pe_cnt - pe0), 32'd1);
    check("par_bad_valid", 32'(host_if.valid), 32'd0);
    check("par_bad_no_ovr", 32'(ovr_cnt - ovr0), 32'd0);
`else
    pe0 = pe_cnt;
    check("no_parity_pulses", 32'(pe_cnt - pe0 + int'(host_if.parity_error)), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
